// File: rtl/nf_fu_pkg.sv
// nf_fu_pkg: shared definitions for the nanoFOX fetch unit.
//   fetch_state_e : fetch FSM states (IDLE, REQ, DRAIN, FLUSH, HALT)
//   NF_NOP        : instruction presented out of reset (addi x0,x0,0)
//   NF_RESET_PC   : default first fetch address
//   NF_PC_STEP    : sequential PC increment
//   nf_pc_next()  : sequential next PC, wraps modulo 2^32
package nf_fu_pkg;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_DRAIN = 3'd2,
    FS_FLUSH = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NF_NOP      = 32'h0000_0013;
  localparam logic [31:0] NF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NF_PC_STEP  = 32'd4;

  function automatic logic [31:0] nf_pc_next(input logic [31:0] pc);
    return pc + NF_PC_STEP;
  endfunction

endpackage

// File: rtl/nf_fu_skid_buf.sv
// nf_fu_skid_buf: one-entry {instr, pc} holding register used when the
// decode stage stalls while a fetch completes.
//   clk, resetn       : clock, asynchronous active-low reset
//   load              : capture d_instr/d_pc and mark the entry valid
//   clear             : empty the entry (wins over load)
//   d_instr, d_pc     : incoming instruction word and its PC
//   q_instr, q_pc     : held instruction word and its PC
//   valid             : entry holds a live instruction
module nf_fu_skid_buf
  import nf_fu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc,
  output logic        valid
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid   <= 1'b0;
      q_instr <= NF_NOP;
      q_pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/nf_fetch_unit.sv
// nf_fetch_unit: instruction fetch unit for the nanoFOX core. Owns the PC,
// drives the instruction-memory port, presents {instr, instr_pc} to decode,
// absorbs decode stalls with a one-entry skid buffer and redirects on taken
// branches, discarding in-flight fetches.
//
// Optional feature macro NF_FU_MISALIGN_EN: when defined, a branch to a
// target with nonzero low bits sets a sticky misalign flag and halts fetch
// (after any outstanding request completes). When undefined the low target
// bits are forced to zero and misalign is tied low.
//
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   addr_i, req_i        : memory address (the fetch PC) and request
//   rd_i, ack_i          : memory read data and response
//   stall                : decode cannot accept a new instruction
//   branch_taken/_target : one-cycle redirect pulse and its address
//   instr, instr_pc      : instruction to decode and its PC
//   instr_valid          : instr holds a live instruction
//   misalign             : sticky misaligned-target flag
//   state                : current fetch FSM state (debug visibility)
//
// Memory handshake: req_i is high in REQ and FLUSH. Once req_i is high the
// request at addr_i is outstanding; addr_i stays stable and req_i stays high
// until the cycle ack_i is sampled high, which completes it with rd_i.
// ack_i may already be high in the first cycle of a request.
module nf_fetch_unit
  import nf_fu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = NF_RESET_PC
) (
  input  logic         clk,
  input  logic         resetn,
  output logic [31:0]  addr_i,
  output logic         req_i,
  input  logic [31:0]  rd_i,
  input  logic         ack_i,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic         instr_valid,
  output logic         misalign,
  output fetch_state_e state
);

  fetch_state_e state_q, state_n;
  logic [31:0]  pc_q, pc_n;
  logic [31:0]  redir_q, redir_n;
  logic [31:0]  instr_q, instr_n;
  logic [31:0]  ipc_q, ipc_n;
  logic         valid_q, valid_n;
  logic         mis_q, mis_n;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc;
  logic         free, bad_tgt;
  logic [31:0]  tgt;

  // Decode can take a new word when nothing live is held or it is not stalled.
  assign free = !valid_q || !stall;
  assign tgt  = branch_target & ~32'h3;

`ifdef NF_FU_MISALIGN_EN
  assign bad_tgt  = (branch_target[1:0] != 2'b00);
  assign misalign = mis_q;
`else
  assign bad_tgt  = 1'b0;
  assign misalign = 1'b0;
`endif

  nf_fu_skid_buf u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_instr (rd_i),
    .d_pc    (pc_q),
    .q_instr (skid_instr),
    .q_pc    (skid_pc),
    .valid   (skid_valid)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      instr_q <= NF_NOP;
      ipc_q   <= 32'h0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      redir_q <= redir_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      valid_q <= valid_n;
      mis_q   <= mis_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    redir_n    = redir_q;
    instr_n    = instr_q;
    ipc_n      = ipc_q;
    valid_n    = valid_q;
    mis_n      = mis_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    case (state_q)
      FS_IDLE: begin
        state_n = FS_REQ;
        if (branch_taken) begin
          if (bad_tgt) begin
            mis_n   = 1'b1;
            state_n = FS_HALT;
          end else begin
            pc_n = tgt;
          end
        end
      end

      FS_REQ: begin
        if (branch_taken) begin
          if (bad_tgt) begin
            mis_n   = 1'b1;
            state_n = ack_i ? FS_HALT : FS_FLUSH;
          end else if (ack_i) begin
            pc_n = tgt;                  // completing data is dropped
          end else begin
            redir_n = tgt;               // wait for the old request first
            state_n = FS_FLUSH;
          end
        end else if (ack_i) begin
          pc_n = nf_pc_next(pc_q);
          if (free) begin
            instr_n = rd_i;
            ipc_n   = pc_q;
            valid_n = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_n   = FS_DRAIN;
          end
        end else if (free) begin
          valid_n = 1'b0;
        end
      end

      FS_DRAIN: begin
        if (branch_taken) begin
          if (bad_tgt) begin
            mis_n   = 1'b1;
            state_n = FS_HALT;
          end else begin
            pc_n    = tgt;
            state_n = FS_REQ;
          end
        end else if (!stall) begin
          instr_n    = skid_instr;
          ipc_n      = skid_pc;
          valid_n    = skid_valid;
          skid_clear = 1'b1;
          state_n    = FS_REQ;
        end
      end

      FS_FLUSH: begin
        if (mis_q) begin
          // Halt is pending: only wait out the outstanding request.
          if (ack_i) state_n = FS_HALT;
        end else if (branch_taken) begin
          if (bad_tgt) begin
            mis_n = 1'b1;
            if (ack_i) state_n = FS_HALT;
          end else if (ack_i) begin
            pc_n    = tgt;
            state_n = FS_REQ;
          end else begin
            redir_n = tgt;               // latest target wins
          end
        end else if (ack_i) begin
          pc_n    = redir_q;
          state_n = FS_REQ;
        end
      end

`ifdef NF_FU_MISALIGN_EN
      FS_HALT: begin
        state_n = FS_HALT;
      end
`endif

      default: state_n = FS_IDLE;
    endcase

    // A redirect always squashes whatever decode or the skid holds.
    if (branch_taken && state_q != FS_HALT) begin
      valid_n    = 1'b0;
      skid_clear = 1'b1;
    end
  end

  assign addr_i      = pc_q;
  assign req_i       = (state_q == FS_REQ) || (state_q == FS_FLUSH);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign state       = state_q;

endmodule

// File: tb/tb_nf_fetch_unit.sv
// tb_nf_fetch_unit: directed steps followed by a randomized phase for
// nf_fetch_unit. Memory returns addr+0x100 after a chosen number of wait
// cycles. The reference model is an instruction-stream view: decode must
// see consecutive PCs (step 4, wrapping) starting at the reset PC, and a
// taken branch restarts the stream at the (aligned) target.
module tb_nf_fetch_unit;
  import nf_fu_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  addr_i;
  logic         req_i;
  logic [31:0]  rd_i = 32'h0;
  logic         ack_i = 1'b0;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [31:0]  branch_target = 32'h0;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         instr_valid;
  logic         misalign;
  fetch_state_e state;

  int checks = 0;
  int errors = 0;
  int n_cons = 0;
  int wait_left = 0;
  int max_lat = 0;
  logic         prev_req = 1'b0;
  logic         prev_ack = 1'b0;
  logic [31:0]  prev_addr = 32'h0;
  logic [31:0]  exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  nf_fetch_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .addr_i        (addr_i),
    .req_i         (req_i),
    .rd_i          (rd_i),
    .ack_i         (ack_i),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .misalign      (misalign),
    .state         (state)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    ack_i         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    wait_left     = 0;
    prev_req      = 1'b0;
    prev_ack      = 1'b0;
    exp_q.delete();
    exp_q.push_back(NF_RESET_PC);
  endtask

  // ---------------- driver: one clock cycle ----------------
  // At the falling edge: check the handshake and the delivered stream,
  // then drive memory response, stall and branch for the next rising edge.
  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt);
    logic [31:0] e;
    @(negedge clk);
    if (prev_req && !prev_ack) begin
      chk("hold_req", {31'h0, req_i}, 32'd1);
      chk("hold_addr", addr_i, prev_addr);
    end
    if (br) begin
      exp_q.delete();
      exp_q.push_back(tgt & ~32'h3);
    end else if (instr_valid && !st) begin
      e = exp_q.pop_front();
      chk("stream_pc", instr_pc, e);
      chk("stream_data", instr, e + 32'h100);
      exp_q.push_back(e + 32'd4);
      n_cons++;
    end
    if (req_i && wait_left == 0) begin
      ack_i     = 1'b1;
      rd_i      = addr_i + 32'h100;
      wait_left = int'($urandom_range(0, max_lat));
    end else begin
      ack_i = 1'b0;
      rd_i  = $urandom;
      if (req_i && wait_left > 0) wait_left--;
    end
    prev_req      = req_i;
    prev_ack      = ack_i;
    prev_addr     = addr_i;
    stall         = st;
    branch_taken  = br;
    branch_target = br ? tgt : $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cons0;
    logic [31:0] rt;
    reset_model();
    repeat (2) @(negedge clk);

    chk("rst_addr", addr_i, NF_RESET_PC);
    chk("rst_req", {31'h0, req_i}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_misalign", {31'h0, misalign}, 32'd0);
    chk("rst_state", 32'(state), 32'(FS_IDLE));

    resetn = 1'b1;
    chk("idle_req", {31'h0, req_i}, 32'd0);

    // zero-wait start-up
    cycle(1'b0, 1'b0, 32'h0);
    chk("first_req", {31'h0, req_i}, 32'd1);
    chk("first_addr", addr_i, 32'h0);
    chk("first_valid_lo", {31'h0, instr_valid}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("first_valid_hi", {31'h0, instr_valid}, 32'd1);
    cycle(1'b0, 1'b0, 32'h0);

    // five stall cycles holding instr@0x8; 0xC parks in the skid
    cycle(1'b1, 1'b0, 32'h0);
    chk("stall_pc", instr_pc, 32'h8);
    repeat (4) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("drain_req", {31'h0, req_i}, 32'd0);
      chk("drain_state", 32'(state), 32'(FS_DRAIN));
      chk("drain_pc", instr_pc, 32'h8);
    end
    cycle(1'b0, 1'b0, 32'h0);

    // resume, then a request with three wait cycles
    wait_left = 3;
    cycle(1'b0, 1'b0, 32'h0);
    chk("resume_pc", instr_pc, 32'hC);
    chk("resume_req", {31'h0, req_i}, 32'd1);
    chk("resume_addr", addr_i, 32'h10);
    repeat (3) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk("wait_addr", addr_i, 32'h10);
      chk("wait_req", {31'h0, req_i}, 32'd1);
      chk("wait_valid", {31'h0, instr_valid}, 32'd0);
    end

    // branch to 0x40 while 0x14 is pending (ack two cycles later)
    wait_left = 2;
    cycle(1'b0, 1'b1, 32'h40);
    chk("br_pend_shown", instr_pc, 32'h10);
    cycle(1'b0, 1'b0, 32'h0);
    chk("flush_state", 32'(state), 32'(FS_FLUSH));
    chk("flush_addr", addr_i, 32'h14);
    chk("flush_valid", {31'h0, instr_valid}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("flush_valid2", {31'h0, instr_valid}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("redir_addr", addr_i, 32'h40);
    chk("redir_req", {31'h0, req_i}, 32'd1);

    // branch with same-cycle ack: that data is dropped
    cycle(1'b0, 1'b1, 32'h80);
    chk("br_ack_shown", instr_pc, 32'h40);
    cycle(1'b0, 1'b0, 32'h0);
    chk("br_ack_valid", {31'h0, instr_valid}, 32'd0);
    chk("br_ack_addr", addr_i, 32'h80);
    repeat (2) cycle(1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (5) cycle(1'b0, 1'b0, 32'h0);

    // misaligned target
    cycle(1'b0, 1'b1, 32'h42);
`ifdef NF_FU_MISALIGN_EN
    repeat (4) begin
      cycle(1'b0, 1'b1, 32'h100);
      chk("halt_misalign", {31'h0, misalign}, 32'd1);
      chk("halt_req", {31'h0, req_i}, 32'd0);
      chk("halt_state", 32'(state), 32'(FS_HALT));
      chk("halt_valid", {31'h0, instr_valid}, 32'd0);
    end
`else
    cycle(1'b0, 1'b0, 32'h0);
    chk("align_addr", addr_i, 32'h40);
    chk("align_misalign", {31'h0, misalign}, 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
`endif

    // reset pulse, restart, then reset in the middle of a request
    @(negedge clk);
    resetn = 1'b0;
    reset_model();
    #1;
    chk("rst2_misalign", {31'h0, misalign}, 32'd0);
    chk("rst2_req", {31'h0, req_i}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    wait_left = 5;
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_req", {31'h0, req_i}, 32'd0);
    chk("midrst_addr", addr_i, NF_RESET_PC);
    chk("midrst_valid", {31'h0, instr_valid}, 32'd0);
    chk("midrst_instr", instr, 32'h0000_0013);
    chk("midrst_state", 32'(state), 32'(FS_IDLE));
    reset_model();
    ack_i = 1'b1;                         // stray late ack while idle
    rd_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    chk("late_ack_addr", addr_i, 32'h0);
    chk("late_ack_valid", {31'h0, instr_valid}, 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);

    // randomized phase
    max_lat = 3;
    cons0 = n_cons;
    for (int i = 0; i < 600; i++) begin
`ifdef NF_FU_MISALIGN_EN
      rt = 32'($urandom_range(0, 1023)) << 2;
`else
      rt = 32'($urandom_range(0, 4095));
`endif
      if ($urandom_range(0, 9) == 0) rt = 32'hFFFF_FFF0;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, rt);
    end
    chk("rand_progress", {31'h0, (n_cons - cons0) > 50}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
